div_issue_ctrl: RTL and testbench
=================================

Name: div_issue_ctrl

Overview:
- EX-stage controller for DIV/DIVU, directly upstream of the 20-cycle divider.
- Latches operands from the pipeline, drives the divider start handshake and holds the pipeline stalled until the divider reports ready.
- Captures the divider's {remainder, quotient} result and issues a single HI/LO write strobe.
- Handles flush mid-operation and watches for a hung divider.

Parameters:
- WIDTH, 32, operand width; the divider result is 2*WIDTH.
- TIMEOUT, 40, maximum BUSY cycles before err_o is raised; range 2..255.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- div_req_i  in  1  a DIV/DIVU is in EX this cycle.
- div_signed_i  in  1  1 = DIV (signed), 0 = DIVU.
- rs_data_i  in  WIDTH  dividend.
- rt_data_i  in  WIDTH  divisor.
- flush_i  in  1  pipeline flush/annul of the EX instruction.
- stall_req_o  out  1  hold IF/ID/EX.
- whilo_o  out  1  one-cycle HI/LO write enable.
- hi_o  out  WIDTH  remainder.
- lo_o  out  WIDTH  quotient.
- err_o  out  1  sticky watchdog error.
- div_start_o  out  1  to divider start_i.
- div_signed_o  out  1  to divider signed_div_i.
- div_op1_o  out  WIDTH  to divider opdata1_i.
- div_op2_o  out  WIDTH  to divider opdata2_i.
- div_result_i  in  2*WIDTH  from divider result_o: [2W-1:W] = remainder, [W-1:0] = quotient.
- div_ready_i  in  1  from divider ready_o.

Behaviour:
- Reset (rst=0, asynchronous):
  - state = IDLE, cycle counter = 0.
  - All outputs 0: hi_o, lo_o, div_op*_o, div_signed_o, div_start_o, stall_req_o, whilo_o, err_o.
- States are IDLE, BUSY, DONE.
- IDLE:
  - div_req_i=1 and flush_i=0: stall_req_o=1 combinationally in the same cycle; latch rs/rt/signed into the div_op*/div_signed_o registers; next state BUSY; counter = 0.
  - Otherwise stay in IDLE with stall_req_o=0.
- BUSY:
  - div_start_o=1 (registered: first asserted in the cycle after acceptance) and stall_req_o=1.
  - Operands stay frozen even if the rs/rt inputs change; counter increments by 1 per cycle, saturating.
  - div_ready_i=1: capture hi_o = div_result_i[2W-1:W] and lo_o = div_result_i[W-1:0]; next state DONE.
- DONE (exactly one cycle):
  - whilo_o=1, stall_req_o=0, div_start_o=0.
  - div_req_i is ignored because it still belongs to the completed instruction; next state IDLE.
- Latency: acceptance cycle + 1 + divider latency + 1 to the whilo_o pulse.
- Back-to-back DIVs: the second is accepted in the IDLE cycle that follows DONE.
- flush_i in BUSY:
  - Next state IDLE; div_start_o drops next cycle, which aborts the divider.
  - No whilo_o; hi_o/lo_o unchanged.
  - Flush has priority over a simultaneous div_ready_i.
- flush_i in DONE: whilo_o is suppressed that cycle.
- Watchdog: when the counter reaches TIMEOUT with no ready:
  - err_o=1, sticky until reset.
  - Next state IDLE, stall released, no write.
- div_ready_i outside BUSY is ignored.
- Reset mid-operation: immediate return to the reset values; the divider sees start=0.
- hi_o/lo_o hold the last written values between operations.

Optional Feature:
- Macro DIV_ZERO_BYPASS_EN.
- When defined, a request in IDLE with rt_data_i==0:
  - Skips the divider: div_start_o stays 0 and the FSM goes straight to DONE.
  - Writes hi_o = rs_data_i and lo_o = all ones.
  - stall_req_o=1 only in the acceptance cycle.
- When undefined: zero divisors go through the divider as normal and the result is whatever the divider returns.

Test Plan:
- DIVU 9/5: stall held, whilo_o pulses once → hi_o=4, lo_o=1; stall_req_o=0 in the DONE cycle.
- DIV 0xFFFFFFF9/4 (-7/4) → lo_o=0xFFFFFFFF, hi_o=0xFFFFFFFD.
- DIVU 0xC0000001/0xC0000000, then immediately DIVU 0x440D8492/0x56518478:
  - first → hi_o=1, lo_o=1; second → hi_o=0x440D8492, lo_o=0.
  - Two whilo_o pulses; the second request is accepted the cycle after the first DONE.
- flush_i at BUSY cycle 5 → IDLE next cycle, div_start_o=0, no whilo_o, hi/lo keep their old values; a later 1/2 gives hi=1, lo=0.
- Divider model with ready tied low, TIMEOUT=40 → err_o=1 after 40 BUSY cycles, stall released; rst=0 mid-BUSY clears everything asynchronously.
- With DIV_ZERO_BYPASS_EN, DIVU 7/0 → whilo_o 1 cycle after acceptance, hi_o=7, lo_o=0xFFFFFFFF, div_start_o never 1.

Source files
------------

// File: rtl/div_issue_if.sv
// div_issue_if: pipeline-side and divider-side signals of the DIV/DIVU issue controller.
interface div_issue_if #(parameter int WIDTH = 32);
   logic               div_req_i;
   logic               div_signed_i;
   logic [WIDTH-1:0]   rs_data_i;
   logic [WIDTH-1:0]   rt_data_i;
   logic               flush_i;
   logic               stall_req_o;
   logic               whilo_o;
   logic [WIDTH-1:0]   hi_o;
   logic [WIDTH-1:0]   lo_o;
   logic               err_o;
   logic               div_start_o;
   logic               div_signed_o;
   logic [WIDTH-1:0]   div_op1_o;
   logic [WIDTH-1:0]   div_op2_o;
   logic [2*WIDTH-1:0] div_result_i;
   logic               div_ready_i;
   modport master (
      input  div_req_i, div_signed_i, rs_data_i, rt_data_i, flush_i, div_result_i, div_ready_i,
      output stall_req_o, whilo_o, hi_o, lo_o, err_o, div_start_o, div_signed_o, div_op1_o, div_op2_o
   );
   modport slave (
      output div_req_i, div_signed_i, rs_data_i, rt_data_i, flush_i, div_result_i, div_ready_i,
      input  stall_req_o, whilo_o, hi_o, lo_o, err_o, div_start_o, div_signed_o, div_op1_o, div_op2_o
   );
endinterface

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: EX-stage DIV/DIVU issue controller in front of a multi-cycle divider.
// Optional DIV_ZERO_BYPASS_EN: zero divisors skip the divider and write {rs, all ones}.
module div_issue_ctrl #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 40
) (
   input logic         clk,
   input logic         rst,
   div_issue_if.master d
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t     state, state_nxt;
   logic [7:0] cnt;
   logic       accept, zero_div, capture, timeout;
   assign accept  = state == IDLE && d.div_req_i && !d.flush_i;
`ifdef DIV_ZERO_BYPASS_EN
   assign zero_div = d.rt_data_i == '0;
`else
   assign zero_div = 1'b0;
`endif
   assign capture = state == BUSY && d.div_ready_i && !d.flush_i;
   // cnt is 0 in the first BUSY cycle, so TIMEOUT-1 marks the last allowed one
   assign timeout = state == BUSY && !d.div_ready_i && !d.flush_i && cnt == 8'(TIMEOUT - 1);
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else state <= state_nxt;
   always_comb begin
      state_nxt = IDLE;
      if (accept) state_nxt = zero_div ? DONE : BUSY;
      if (state == BUSY) state_nxt = d.flush_i || timeout ? IDLE : d.div_ready_i ? DONE : BUSY;
   end
   always_comb begin
      d.stall_req_o = state == BUSY || accept;
      d.whilo_o     = state == DONE && !d.flush_i;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt            <= '0;
         d.div_start_o  <= 1'b0;
         d.div_signed_o <= 1'b0;
         d.div_op1_o    <= '0;
         d.div_op2_o    <= '0;
         d.hi_o         <= '0;
         d.lo_o         <= '0;
         d.err_o        <= 1'b0;
      end else begin
         cnt           <= accept ? '0 : state == BUSY && cnt != 8'hFF ? cnt + 8'd1 : cnt;
         d.div_start_o <= state_nxt == BUSY;
         if (accept) begin
            d.div_signed_o <= d.div_signed_i;
            d.div_op1_o    <= d.rs_data_i;
            d.div_op2_o    <= d.rt_data_i;
         end
         if (timeout) d.err_o <= 1'b1;
         if (capture) {d.hi_o, d.lo_o} <= d.div_result_i;
         if (accept && zero_div) begin
            d.hi_o <= d.rs_data_i;
            d.lo_o <= '1;
         end
      end
   end
endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: randomized self-checking bench for div_issue_ctrl with a behavioural divider.
module tb_div_issue_ctrl;
   localparam int W  = 32;
   localparam int TO = 40;
   logic clk = 1'b0, rst = 1'b0, noise = 1'b0;
   int n_chk = 0, n_err = 0, n_wr = 0, exp_wr = 0, n_start = 0, dlat = 20, dcnt = 0;
   logic [W-1:0] exp_hi = '0, exp_lo = '0;
   div_issue_if #(W) v();
   div_issue_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .d(v.master));
   always #5 clk = ~clk;
   function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a, b, input logic s);
      logic signed [W-1:0] q, r;
      if (b == '0) return {a, {W{1'b1}}};
      if (!s) return {a % b, a / b};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      return {r, q};
   endfunction
   // divider model: ready one cycle after dlat cycles of start, noise on ready while not started
   always @(posedge clk) begin
      dcnt <= v.div_start_o ? dcnt + 1 : 0;
      v.div_ready_i  <= v.div_start_o ? dcnt + 1 == dlat : noise;
      v.div_result_i <= v.div_start_o && dcnt + 1 == dlat ?
                        ref_div(v.div_op1_o, v.div_op2_o, v.div_signed_o) : {$urandom, $urandom};
   end
   always @(negedge clk) begin
      if (v.whilo_o === 1'b1) n_wr <= n_wr + 1;
      if (v.div_start_o === 1'b1) n_start <= n_start + 1;
   end
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic idle(input int k);
      noise = 1'b1;
      repeat (k) begin
         @(negedge clk);
         v.div_req_i = 1'($urandom_range(0, 1));
         v.flush_i   = v.div_req_i;
         v.rs_data_i = $urandom;
         v.rt_data_i = $urandom;
         #1 chk("idle_stall", v.stall_req_o, 0);
      end
      noise = 1'b0;
      v.div_req_i = 1'b0;
      v.flush_i   = 1'b0;
      chk("writes", n_wr, exp_wr);
      chk("hold_hi", v.hi_o, exp_hi);
      chk("hold_lo", v.lo_o, exp_lo);
   endtask
   task automatic do_div(input logic [W-1:0] a, b, input logic s, input int lat, input bit b2b, input bit fd);
      logic [2*W-1:0] r;
      int n, lim, ns;
      bit ok, byp;
      r = ref_div(a, b, s);
      ok = 1'b1;
      byp = 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
      byp = b == '0;
`endif
      lim = byp ? 1 : lat + 2;
      dlat = lat;
      ns = n_start;
      v.div_req_i = 1'b1; v.div_signed_i = s; v.rs_data_i = a; v.rt_data_i = b;
      if (b2b) begin
         #1 chk("done_req_stall", v.stall_req_o, 0);
         @(posedge clk);
      end
      #1 chk("accept_stall", v.stall_req_o, 1);
      @(posedge clk);
      #1;
      v.div_req_i = 1'b0; v.rs_data_i = $urandom; v.rt_data_i = $urandom; v.div_signed_i = 1'($urandom);
      for (n = 1; n < lim + 4; n++) begin
         v.flush_i = fd && n == lim;
         @(negedge clk);
         if (v.whilo_o || v.flush_i) break;
         ok &= v.stall_req_o && v.div_start_o;
         @(posedge clk);
         #1;
      end
      chk("latency", n, lim);
      chk("busy_stall_start", ok, 1);
      chk("done_stall", v.stall_req_o, 0);
      chk("done_start", v.div_start_o, 0);
      if (fd) chk("flush_done_whilo", v.whilo_o, 0);
      else begin
         exp_wr++;
         chk("hi", v.hi_o, r[2*W-1:W]);
         chk("lo", v.lo_o, r[W-1:0]);
      end
      if (byp) chk("bypass_no_start", n_start, ns);
      exp_hi = r[2*W-1:W];
      exp_lo = r[W-1:0];
      if (fd) begin
         @(posedge clk);
         #1 v.flush_i = 1'b0;
      end
   endtask
   task automatic do_flush(input logic [W-1:0] a, b, input int k, input int lat);
      dlat = lat;
      v.div_req_i = 1'b1; v.div_signed_i = 1'b0; v.rs_data_i = a; v.rt_data_i = b;
      #1 chk("fl_accept", v.stall_req_o, 1);
      @(posedge clk);
      #1;
      v.div_req_i = 1'b0; v.rs_data_i = $urandom; v.rt_data_i = $urandom;
      repeat (k - 1) begin
         @(posedge clk);
         #1;
      end
      v.flush_i = 1'b1;
      @(negedge clk);
      chk("fl_busy_stall", v.stall_req_o, 1);
      @(posedge clk);
      #1 v.flush_i = 1'b0;
      @(negedge clk);
      chk("fl_idle_stall", v.stall_req_o, 0);
      chk("fl_start", v.div_start_o, 0);
      chk("fl_whilo", v.whilo_o, 0);
      chk("fl_hi", v.hi_o, exp_hi);
      chk("fl_lo", v.lo_o, exp_lo);
   endtask
   task automatic do_timeout;
      int n;
      dlat = 1000;
      v.div_req_i = 1'b1; v.div_signed_i = 1'b0; v.rs_data_i = 5; v.rt_data_i = 3;
      #1 chk("to_accept", v.stall_req_o, 1);
      @(posedge clk);
      #1 v.div_req_i = 1'b0;
      for (n = 1; n <= TO + 5; n++) begin
         @(negedge clk);
         if (!v.stall_req_o) break;
         if (n == TO) chk("err_early", v.err_o, 0);
         @(posedge clk);
         #1;
      end
      chk("to_cycles", n, TO + 1);
      chk("to_err", v.err_o, 1);
      chk("to_start", v.div_start_o, 0);
      chk("to_hi", v.hi_o, exp_hi);
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   initial begin
      logic [W-1:0] a, b;
      logic s;
      bit b2b;
      v.div_req_i = 1'b0; v.div_signed_i = 1'b0; v.flush_i = 1'b0; v.rs_data_i = '0; v.rt_data_i = '0;
      repeat (3) @(negedge clk);
      chk("rst_stall", v.stall_req_o, 0);
      chk("rst_whilo", v.whilo_o, 0);
      chk("rst_err", v.err_o, 0);
      chk("rst_start", v.div_start_o, 0);
      chk("rst_hilo", {v.hi_o, v.lo_o}, 0);
      chk("rst_ops", {v.div_op1_o, v.div_op2_o, v.div_signed_o}, 0);
      rst = 1'b1;
      idle(2);
      do_div(9, 5, 1'b0, 20, 1'b0, 1'b0);
      idle(1);
      do_div(32'hFFFFFFF9, 4, 1'b1, 20, 1'b0, 1'b0);
      idle(1);
      do_div(32'hC0000001, 32'hC0000000, 1'b0, 20, 1'b0, 1'b0);
      do_div(32'h440D8492, 32'h56518478, 1'b0, 20, 1'b1, 1'b0);
      idle(2);
      do_flush(32'h1234, 7, 5, 20);
      idle(1);
      do_div(1, 2, 1'b0, 20, 1'b0, 1'b0);
      idle(1);
      do_flush(32'h9999, 5, 4, 3);
      idle(1);
      do_div(32'h00ABCDEF, 13, 1'b0, 5, 1'b0, 1'b1);
      idle(2);
      do_timeout();
      idle(2);
      do_div(100, 7, 1'b0, 3, 1'b0, 1'b0);
      chk("err_sticky", v.err_o, 1);
      idle(1);
`ifdef DIV_ZERO_BYPASS_EN
      do_div(7, 0, 1'b0, 20, 1'b0, 1'b0);
      idle(2);
`endif
      dlat = 20;
      v.div_req_i = 1'b1; v.rs_data_i = 100; v.rt_data_i = 3; v.div_signed_i = 1'b1;
      @(posedge clk);
      #1 v.div_req_i = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      chk("arst_stall", v.stall_req_o, 0);
      chk("arst_start", v.div_start_o, 0);
      chk("arst_err", v.err_o, 0);
      chk("arst_hilo", {v.hi_o, v.lo_o}, 0);
      chk("arst_ops", {v.div_op1_o, v.div_op2_o, v.div_signed_o}, 0);
      @(negedge clk);
      rst = 1'b1;
      exp_hi = '0;
      exp_lo = '0;
      idle(2);
      for (int i = 0; i < 12; i++) begin
         a = $urandom;
         b = $urandom_range(0, 3) == 0 ? '0 : $urandom >> $urandom_range(0, 31);
         s = 1'($urandom);
         if (s && a == 32'h80000000 && b == '1) b = 1;
         b2b = i > 0 && $urandom_range(0, 1) == 1;
         if (!b2b) idle($urandom_range(1, 3));
         do_div(a, b, s, $urandom_range(1, 20), b2b, 1'b0);
      end
      idle(2);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
